// File: rtl/dcache_pkg.sv
// Shared types and widths for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int OFF_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_FILL
  } state_t;

  function automatic int tag_width(input int idx_w);
    return ADDR_W - idx_w - OFF_W;
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Per-line valid/dirty/tag/data storage: combinational read at idx,
// one synchronous write port with per-field enables.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3,
  parameter int TAG_W     = 27
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  input  logic              we_valid,
  input  logic              we_dirty,
  input  logic              we_tag,
  input  logic              we_data,
  input  logic              wr_valid,
  input  logic              wr_dirty,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [DATA_W-1:0]    data_q [NUM_LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (we_valid) valid_q[idx] <= wr_valid;
      if (we_dirty) dirty_q[idx] <= wr_dirty;
    end
  end

  // Tag and data are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (we_tag)  tag_q[idx]  <= wr_tag;
    if (we_data) data_q[idx] <= wr_data;
  end

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with a
// req/ack initiator port toward the word-addressed data memory.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | serving hits; a miss stalls and picks the next state
// WRITEBACK | dirty victim being written to memory
// FILL      | missing word being read from memory
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadData_o,
  output logic        stall_o,
  output logic        mem_enable_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
);

  localparam int TAG_W = tag_width(IDX_W);

  state_t state_q, state_nxt;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  addr_tag;
  logic              unused_byte_bits;
  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              we_valid, we_dirty, we_tag, we_data;
  logic              wr_dirty;
  logic [DATA_W-1:0] wr_data;
  logic              req, wr_req, hit, victim_dirty, ack;
  logic              do_wr_hit, do_install_wr, do_fill, do_clean;
  logic              mem_enable_nxt, mem_write_nxt;
  logic [31:0]       mem_addr_nxt, mem_data_nxt, fill_addr, victim_addr;

  assign idx              = Addr_i[IDX_W+OFF_W-1:OFF_W];
  assign addr_tag         = Addr_i[ADDR_W-1:IDX_W+OFF_W];
  assign unused_byte_bits = ^Addr_i[OFF_W-1:0];

  assign req          = MemRead_i | MemWrite_i;
  assign wr_req       = MemWrite_i;
  assign hit          = rd_valid & (rd_tag == addr_tag);
  assign victim_dirty = rd_valid & rd_dirty;
  assign ack          = mem_ack_i & mem_enable_o;
  assign fill_addr    = {Addr_i[31:OFF_W], 2'b00};
  assign victim_addr  = {rd_tag, idx, 2'b00};

  dcache_line_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_lines (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .idx      (idx),
    .we_valid (we_valid),
    .we_dirty (we_dirty),
    .we_tag   (we_tag),
    .we_data  (we_data),
    .wr_valid (1'b1),
    .wr_dirty (wr_dirty),
    .wr_tag   (addr_tag),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  always_comb begin
    state_nxt      = state_q;
    mem_enable_nxt = mem_enable_o;
    mem_write_nxt  = mem_write_o;
    mem_addr_nxt   = mem_addr_o;
    mem_data_nxt   = mem_data_o;
    do_wr_hit      = 1'b0;
    do_install_wr  = 1'b0;
    do_fill        = 1'b0;
    do_clean       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req && hit) begin
          do_wr_hit = wr_req;
        end else if (req && victim_dirty) begin
          state_nxt      = ST_WRITEBACK;
          mem_enable_nxt = 1'b1;
          mem_write_nxt  = 1'b1;
          mem_addr_nxt   = victim_addr;
          mem_data_nxt   = rd_data;
        end else if (wr_req) begin
          // A line is one word, so a store miss needs no fill.
          do_install_wr = 1'b1;
        end else if (req) begin
          state_nxt      = ST_FILL;
          mem_enable_nxt = 1'b1;
          mem_write_nxt  = 1'b0;
          mem_addr_nxt   = fill_addr;
        end
      end

      ST_WRITEBACK: begin
        if (ack) begin
          do_clean = 1'b1;
          if (wr_req) begin
            do_install_wr  = 1'b1;
            state_nxt      = ST_IDLE;
            mem_enable_nxt = 1'b0;
            mem_write_nxt  = 1'b0;
          end else begin
            state_nxt     = ST_FILL;
            mem_write_nxt = 1'b0;
            mem_addr_nxt  = fill_addr;
          end
        end
      end

      ST_FILL: begin
        if (ack) begin
          do_fill        = 1'b1;
          state_nxt      = ST_IDLE;
          mem_enable_nxt = 1'b0;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    we_valid = do_install_wr | do_fill;
    we_tag   = do_install_wr | do_fill;
    we_data  = do_wr_hit | do_install_wr | do_fill;
    we_dirty = do_wr_hit | do_install_wr | do_fill | do_clean;
    wr_dirty = do_wr_hit | do_install_wr;
    wr_data  = do_fill ? mem_data_i : WriteData_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      state_q      <= state_nxt;
      mem_enable_o <= mem_enable_nxt;
      mem_write_o  <= mem_write_nxt;
      mem_addr_o   <= mem_addr_nxt;
      mem_data_o   <= mem_data_nxt;
    end
  end

  // Reset gates stall so the pipeline is never frozen while held in reset.
  assign stall_o    = rst_i & ((state_q != ST_IDLE) | (req & ~hit));
  assign ReadData_o = (state_q == ST_IDLE && MemRead_i && !MemWrite_i && hit)
                      ? rd_data : 32'h0;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: hits, clean/dirty misses, store misses and reset abort.
module tb_dcache_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i;
  logic [31:0] Addr_i, WriteData_i;
  logic [31:0] ReadData_o;
  logic        stall_o;
  logic        mem_enable_o, mem_write_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;

  int total = 0;
  int bad   = 0;

  dcache_ctrl #(.NUM_LINES(8), .IDX_W(3)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .MemRead_i    (MemRead_i),
    .MemWrite_i   (MemWrite_i),
    .Addr_i       (Addr_i),
    .WriteData_i  (WriteData_i),
    .ReadData_o   (ReadData_o),
    .stall_o      (stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_out(input string tag);
    chk({tag, "_stall"}, {31'b0, stall_o}, 32'd0);
    chk({tag, "_en"}, {31'b0, mem_enable_o}, 32'd0);
  endtask

  initial begin
    rst_i = 1'b0; MemRead_i = 1'b1; MemWrite_i = 1'b0; Addr_i = 32'h10;
    WriteData_i = 32'h0; mem_ack_i = 1'b0; mem_data_i = 32'h0;
    #2;
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_en", {31'b0, mem_enable_o}, 32'd0);
    chk("rst_wr", {31'b0, mem_write_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_mdata", mem_data_o, 32'h0);
    chk("rst_rdata", ReadData_o, 32'h0);
    cyc(); cyc();

    // cold read of 0x10, ack in cycle 3
    rst_i = 1'b1; #2;
    chk("cold_c0_stall", {31'b0, stall_o}, 32'd1);
    chk("cold_c0_en", {31'b0, mem_enable_o}, 32'd0);
    cyc(); #2;
    chk("cold_c1_stall", {31'b0, stall_o}, 32'd1);
    chk("cold_c1_en", {31'b0, mem_enable_o}, 32'd1);
    chk("cold_c1_wr", {31'b0, mem_write_o}, 32'd0);
    chk("cold_c1_addr", mem_addr_o, 32'h10);
    cyc(); #2;
    chk("cold_c2_stall", {31'b0, stall_o}, 32'd1);
    cyc(); mem_ack_i = 1'b1; mem_data_i = 32'hDEAD_BEEF; #2;
    chk("cold_c3_stall", {31'b0, stall_o}, 32'd1);
    cyc(); mem_ack_i = 1'b0; mem_data_i = 32'h0; #2;
    idle_out("cold_c4");
    chk("cold_c4_rdata", ReadData_o, 32'hDEAD_BEEF);

    // store hit then load hit
    cyc(); MemRead_i = 1'b0; MemWrite_i = 1'b1; WriteData_i = 32'h1234_5678; #2;
    idle_out("st_hit");
    chk("st_hit_rdata", ReadData_o, 32'h0);
    cyc(); MemRead_i = 1'b1; MemWrite_i = 1'b0; #2;
    idle_out("ld_hit");
    chk("ld_hit_rdata", ReadData_o, 32'h1234_5678);

    // dirty read miss at 0x30 evicting 0x10
    cyc(); Addr_i = 32'h30; #2;
    chk("dm_c0_stall", {31'b0, stall_o}, 32'd1);
    chk("dm_c0_en", {31'b0, mem_enable_o}, 32'd0);
    chk("dm_c0_rdata", ReadData_o, 32'h0);
    cyc(); #2;
    chk("dm_wb_en", {31'b0, mem_enable_o}, 32'd1);
    chk("dm_wb_wr", {31'b0, mem_write_o}, 32'd1);
    chk("dm_wb_addr", mem_addr_o, 32'h10);
    chk("dm_wb_data", mem_data_o, 32'h1234_5678);
    cyc(); mem_ack_i = 1'b1; #2;
    chk("dm_wb2_en", {31'b0, mem_enable_o}, 32'd1);
    cyc(); mem_ack_i = 1'b0; #2;
    chk("dm_fill_en", {31'b0, mem_enable_o}, 32'd1);
    chk("dm_fill_wr", {31'b0, mem_write_o}, 32'd0);
    chk("dm_fill_addr", mem_addr_o, 32'h30);
    chk("dm_fill_stall", {31'b0, stall_o}, 32'd1);
    cyc(); mem_ack_i = 1'b1; mem_data_i = 32'hCAFE_F00D; #2;
    chk("dm_fill2_stall", {31'b0, stall_o}, 32'd1);
    cyc(); mem_ack_i = 1'b0; mem_data_i = 32'h0; #2;
    idle_out("dm_done");
    chk("dm_done_rdata", ReadData_o, 32'hCAFE_F00D);

    // store miss to invalid line 0x08: one stall cycle, no traffic
    cyc(); MemRead_i = 1'b0; MemWrite_i = 1'b1; Addr_i = 32'h08; WriteData_i = 32'hA5A5_A5A5; #2;
    chk("smiss_c0_stall", {31'b0, stall_o}, 32'd1);
    chk("smiss_c0_en", {31'b0, mem_enable_o}, 32'd0);
    cyc(); #2;
    idle_out("smiss_c1");
    cyc(); MemRead_i = 1'b1; MemWrite_i = 1'b0; #2;
    chk("smiss_ld", ReadData_o, 32'hA5A5_A5A5);

    // evict 0x08 with a load of 0x28
    cyc(); Addr_i = 32'h28; #2;
    chk("ev_c0_stall", {31'b0, stall_o}, 32'd1);
    cyc(); mem_ack_i = 1'b1; #2;
    chk("ev_wb_en", {31'b0, mem_enable_o}, 32'd1);
    chk("ev_wb_wr", {31'b0, mem_write_o}, 32'd1);
    chk("ev_wb_addr", mem_addr_o, 32'h08);
    chk("ev_wb_data", mem_data_o, 32'hA5A5_A5A5);
    cyc(); mem_data_i = 32'h1111_2222; #2;
    chk("ev_fill_wr", {31'b0, mem_write_o}, 32'd0);
    chk("ev_fill_addr", mem_addr_o, 32'h28);
    cyc(); mem_ack_i = 1'b0; mem_data_i = 32'h0; #2;
    idle_out("ev_done");
    chk("ev_done_rdata", ReadData_o, 32'h1111_2222);

    // store miss with dirty victim: write-back of 0x28, then install
    cyc(); MemRead_i = 1'b0; MemWrite_i = 1'b1; WriteData_i = 32'h0BAD_F00D; #2;
    idle_out("dsm_pre");
    cyc(); Addr_i = 32'h08; WriteData_i = 32'h7777_8888; #2;
    chk("dsm_c0_stall", {31'b0, stall_o}, 32'd1);
    cyc(); mem_ack_i = 1'b1; #2;
    chk("dsm_wb_en", {31'b0, mem_enable_o}, 32'd1);
    chk("dsm_wb_addr", mem_addr_o, 32'h28);
    chk("dsm_wb_data", mem_data_o, 32'h0BAD_F00D);
    cyc(); mem_ack_i = 1'b0; #2;
    idle_out("dsm_done");
    cyc(); MemRead_i = 1'b1; MemWrite_i = 1'b0; #2;
    chk("dsm_ld", ReadData_o, 32'h7777_8888);

    // read and write together on a hit acts as a write
    cyc(); MemWrite_i = 1'b1; WriteData_i = 32'h55AA_55AA; #2;
    chk("both_rdata", ReadData_o, 32'h0);
    chk("both_stall", {31'b0, stall_o}, 32'd0);
    cyc(); MemWrite_i = 1'b0; #2;
    chk("both_ld", ReadData_o, 32'h55AA_55AA);

    // reset during write-back of dirty 0x08 (load 0x48, same index)
    cyc(); Addr_i = 32'h48; #2;
    chk("rwb_c0_stall", {31'b0, stall_o}, 32'd1);
    cyc(); #2;
    chk("rwb_en", {31'b0, mem_enable_o}, 32'd1);
    chk("rwb_addr", mem_addr_o, 32'h08);
    rst_i = 1'b0; #1;
    chk("rwb_drop_en", {31'b0, mem_enable_o}, 32'd0);
    chk("rwb_drop_stall", {31'b0, stall_o}, 32'd0);
    chk("rwb_drop_addr", mem_addr_o, 32'h0);
    cyc(); rst_i = 1'b1; MemRead_i = 1'b0; #2;
    chk("rwb_post_en", {31'b0, mem_enable_o}, 32'd0);
    MemRead_i = 1'b1; Addr_i = 32'h10; #1;
    chk("rwb_miss10", {31'b0, stall_o}, 32'd1);
    Addr_i = 32'h30; #1;
    chk("rwb_miss30", {31'b0, stall_o}, 32'd1);
    Addr_i = 32'h08; #1;
    chk("rwb_miss08", {31'b0, stall_o}, 32'd1);
    chk("rwb_miss08_rdata", ReadData_o, 32'h0);
    MemRead_i = 1'b0;
    cyc(); #2;
    idle_out("rwb_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller between the CPU MEM stage and the word-addressed `Data_Memory` backing store. It answers CPU `MemRead`/`MemWrite` accesses with zero-cycle hits. On a miss it stalls the pipeline and runs a request/acknowledge handshake toward memory to write back a dirty victim and/or fill the line. It is the initiator on the memory interface; the data memory is the responder.

## Interface
- `NUM_LINES`, 8, number of cache lines (power of two); each line holds one 32-bit word
- `IDX_W`, 3, index width, log2(`NUM_LINES`)
- `clk_i` in 1, clock, rising edge
- `rst_i` in 1, reset; **one clock; reset is asynchronous and active-low**
- `MemRead_i` in 1, CPU load request
- `MemWrite_i` in 1, CPU store request
- `Addr_i` in 32, CPU byte address; bits [1:0] ignored
- `WriteData_i` in 32, CPU store data
- `ReadData_o` out 32, load data, valid when `MemRead_i`=1 and `stall_o`=0
- `stall_o` out 1, freeze pipeline; CPU holds all request inputs stable while it is 1
- `mem_enable_o` out 1, memory request valid
- `mem_write_o` out 1, 1 = write-back, 0 = fill read
- `mem_addr_o` out 32, word-aligned memory address
- `mem_data_o` out 32, write-back data
- `mem_ack_i` in 1, one-cycle pulse; request done; `mem_data_i` valid for a fill
- `mem_data_i` in 32, fill data

## Operation
- Address split: index = `Addr_i[IDX_W+1:2]`; tag = `Addr_i[31:IDX_W+2]`.
- Per line: valid, dirty, tag, data. Reset clears every valid and dirty bit. Data and tag contents are don't-care after reset.
- Hit = line valid and tag equal. Request = `MemRead_i` | `MemWrite_i`. If both are 1, the access is a write: `ReadData_o`=0, no read result.
- States: IDLE, WRITEBACK, FILL.
- IDLE:
  - Read hit: `ReadData_o` = line data, combinationally.
  - Write hit: line data ← `WriteData_i` and dirty ← 1 at the clock edge.
  - Miss with valid and dirty victim: go to WRITEBACK.
  - Miss otherwise: a read goes to FILL. A write installs directly (tag, valid=1, dirty=1, data) at the edge; no memory traffic, because the line is a single word.
- WRITEBACK:
  - Drive `mem_enable_o`=1, `mem_write_o`=1, `mem_addr_o`={victim tag, index, 2'b00}, `mem_data_o`=victim data.
  - On `mem_ack_i`: dirty ← 0. A read miss goes to FILL. A write miss installs as above and goes to IDLE.
- FILL:
  - Drive `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o`={`Addr_i`[31:2], 2'b00}.
  - On `mem_ack_i`: install tag, valid=1, dirty=0, data=`mem_data_i`; go to IDLE. The access then hits.
- `stall_o` = (state≠IDLE) | (request & miss in IDLE). It is combinational.
- `mem_*` outputs come from registers only. Reset values: `mem_enable_o`=0, `mem_write_o`=0, `mem_addr_o`=0, `mem_data_o`=0.
- `ReadData_o` is 0 whenever there is no read hit in IDLE. `stall_o` is 0 in reset.
- `mem_ack_i` is ignored when `mem_enable_o`=0.
- Reset mid-miss aborts the transaction immediately: `mem_enable_o` drops asynchronously, and the pending write-back is lost by design.

## Timing
- Hit: zero latency; `stall_o` stays 0.
- Read miss, clean victim: request seen at cycle 0 with `stall_o`=1. `mem_enable_o`=1 from cycle 1. Ack in cycle k causes install at edge k+1. Cycle k+1 is IDLE with a hit: `stall_o`=0 and `ReadData_o` valid. Total stall = k+1 cycles.
- Dirty read miss: WRITEBACK, then `mem_enable_o` stays 1 continuously into FILL. `mem_write_o` and `mem_addr_o` change on the edge after the write-back ack.
- The request is held stable until ack. There is exactly one outstanding memory request.

## Structure
- Package `dcache_pkg`: state enum (IDLE, WRITEBACK, FILL), address/tag/index width constants.
- Sub-module `dcache_line_array` holds the valid/dirty/tag/data storage:
  - combinational read port at the index;
  - single synchronous write port with per-field enables;
  - async clear of valid/dirty.
- The controller FSM lives in `dcache_ctrl`.

## Test plan
- Cold read at 0x0000_0010: memory acks `mem_data_i`=0xDEAD_BEEF after 3 cycles -> `mem_addr_o`=0x10 with `mem_write_o`=0; `stall_o` for 4 cycles; then `ReadData_o`=0xDEAD_BEEF.
- Store 0x1234_5678 to 0x10 after the fill, then load 0x10 -> no memory traffic, `stall_o`=0, `ReadData_o`=0x1234_5678.
- Load 0x30 (same index 4, different tag) with line 0x10 dirty -> write-back at 0x10 with `mem_data_o`=0x1234_5678, then fill read at 0x30, then the load completes.
- Store-miss to a clean or invalid line at 0x08 -> no `mem_enable_o`; `stall_o` for exactly 1 cycle; later evicting it issues a write-back at 0x08.
- `MemRead_i`=`MemWrite_i`=1 on a hit -> data updated, `ReadData_o`=0.
- Assert `rst_i`=0 during WRITEBACK -> `mem_enable_o` drops in the same cycle; after release, all lines are invalid and a load of 0x10 misses.
